aes_spi_host: RTL and testbench

AES_SPI_HOST -- requirements
Module: aes_spi_host

---
 rtl/aes_spi_host_if.sv | 26 ++
 rtl/aes_spi_host.sv | 159 +++++++++++++++
 tb/tb_aes_spi_host.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_spi_host_if.sv
// Request/result bus between a client and aes_spi_host.
//   master: drives start, data_in, key_in; observes ready, data_out, out_valid, timeout_err
//   slave : the host block (opposite directions)
interface aes_spi_host_if #(
  parameter int unsigned Nk = 6
);
  localparam int unsigned KeyW = 32 * Nk;

  logic            start;
  logic            ready;
  logic [127:0]    data_in;
  logic [KeyW-1:0] key_in;
  logic [127:0]    data_out;
  logic            out_valid;
  logic            timeout_err;

  modport master (
    output start, data_in, key_in,
    input  ready, data_out, out_valid, timeout_err
  );

  modport slave (
    input  start, data_in, key_in,
    output ready, data_out, out_valid, timeout_err
  );
endinterface

// File: rtl/aes_spi_host.sv
// Serial host for a bit-serial AES core: captures one block plus key, shifts
// them into the core LSB first, waits (bounded) for finished, then shifts the
// 128-bit result back in and presents it with a one-cycle valid pulse.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : start/ready handshake, data_in, key_in, data_out,
//                   out_valid pulse, sticky timeout_err
//   cs, miso      : chip select and serial data toward the core
//   mosi          : serial result data from the core
//   finished      : core completion flag
module aes_spi_host #(
  parameter int unsigned Nk      = 6,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  aes_spi_host_if.slave bus,
  output logic        cs,
  output logic        miso,
  input  logic        mosi,
  input  logic        finished
);

  localparam int unsigned KeyW     = 32 * Nk;
  localparam int unsigned LoadBits = 128 + KeyW;
  // Sized for the largest key (Nk=8, 384 bits) regardless of Nk.
  localparam int unsigned BitW     = $clog2(128 + 32 * 8);
  localparam int unsigned RunW     = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, LOAD, RUN, OSETUP, READ, DONE, ERR
  } state_t;

  state_t              state, nextState;
  logic [BitW-1:0]     bitCnt, bitCntNext;
  logic [RunW-1:0]     runCnt, runCntNext;
  logic [LoadBits-1:0] shiftReg, shiftNext;
  logic [127:0]        dataOutReg, dataOutNext;
  logic                csReg, csNext;
  logic                misoReg, misoNext;
  logic                readyReg, readyNext;
  logic                outValidReg, outValidNext;
  logic                timeoutErrReg, timeoutErrNext;
  logic                accept;

  // Next-state, counters and registered-output next values.
  always_comb begin
    nextState      = state;
    bitCntNext     = bitCnt;
    runCntNext     = runCnt;
    shiftNext      = shiftReg;
    dataOutNext    = dataOutReg;
    timeoutErrNext = timeoutErrReg;
    accept         = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          nextState = SETUP;
        end
      end
      SETUP: begin
        nextState  = LOAD;
        bitCntNext = '0;
      end
      LOAD: begin
        if (bitCnt == BitW'(LoadBits - 1)) begin
          nextState  = RUN;
          bitCntNext = '0;
          runCntNext = '0;
        end else begin
          bitCntNext = bitCnt + BitW'(1);
        end
      end
      RUN: begin
        // finished is ignored in the first RUN cycle and wins over timeout.
        if ((runCnt != '0) && finished) begin
          nextState  = OSETUP;
          runCntNext = '0;
        end else if (runCnt == RunW'(TIMEOUT - 1)) begin
          nextState  = ERR;
          runCntNext = '0;
        end else begin
          runCntNext = runCnt + RunW'(1);
        end
      end
      OSETUP: begin
        nextState  = READ;
        bitCntNext = '0;
      end
      READ: begin
        dataOutNext = {mosi, dataOutReg[127:1]};
        if (bitCnt == BitW'(127)) begin
          nextState  = DONE;
          bitCntNext = '0;
        end else begin
          bitCntNext = bitCnt + BitW'(1);
        end
      end
      DONE:    nextState = IDLE;
      ERR:     nextState = IDLE;
      default: nextState = IDLE;
    endcase

    // Capture key above data so one right-shift serializes data then key.
    if (accept) begin
      shiftNext      = {bus.key_in, bus.data_in};
      timeoutErrNext = 1'b0;
    end else if (nextState == LOAD) begin
      shiftNext = shiftReg >> 1;
    end

    if (nextState == ERR) begin
      timeoutErrNext = 1'b1;
    end

    csNext       = (nextState == SETUP) || (nextState == LOAD) ||
                   (nextState == OSETUP) || (nextState == READ);
    misoNext     = (nextState == LOAD) ? shiftReg[0] : 1'b0;
    readyNext    = (nextState == IDLE);
    outValidNext = (nextState == DONE);
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bitCnt        <= '0;
      runCnt        <= '0;
      shiftReg      <= '0;
      dataOutReg    <= '0;
      csReg         <= 1'b0;
      misoReg       <= 1'b0;
      readyReg      <= 1'b1;
      outValidReg   <= 1'b0;
      timeoutErrReg <= 1'b0;
    end else begin
      state         <= nextState;
      bitCnt        <= bitCntNext;
      runCnt        <= runCntNext;
      shiftReg      <= shiftNext;
      dataOutReg    <= dataOutNext;
      csReg         <= csNext;
      misoReg       <= misoNext;
      readyReg      <= readyNext;
      outValidReg   <= outValidNext;
      timeoutErrReg <= timeoutErrNext;
    end
  end

  assign cs              = csReg;
  assign miso            = misoReg;
  assign bus.ready       = readyReg;
  assign bus.data_out    = dataOutReg;
  assign bus.out_valid   = outValidReg;
  assign bus.timeout_err = timeoutErrReg;

endmodule

// File: tb/tb_aes_spi_host.sv
// Directed bench for aes_spi_host (Nk=6, TIMEOUT=64) with a behavioral core
// that records the serialized block/key and returns a known result block.
module tb_aes_spi_host;

  localparam int unsigned KeyW     = 192;
  localparam int unsigned LoadBits = 320;

  localparam logic [127:0]  D1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [KeyW-1:0] K1 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0]  C1 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0]  D2 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [KeyW-1:0] K2 = 192'h123456789876543223456789876543212345789876543210;
  localparam logic [127:0]  C2 = 128'hb81a4b66ebdee44d6fc0f886cc442d7b;

  logic clk = 1'b0;
  logic rst;
  logic cs, miso, mosi, finished;

  aes_spi_host_if #(.Nk(6)) bus ();

  aes_spi_host #(.Nk(6), .TIMEOUT(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .cs       (cs),
    .miso     (miso),
    .mosi     (mosi),
    .finished (finished)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Results recorded by runTxn.
  logic [LoadBits-1:0] rx;
  int   csRun, runCycles, ovCount, ovCycle;
  logic toSeen, toCycle1, setupMiso, runMiso, readyDone, idleReady, idleCs, idleTo, hung;

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction, observed and driven once per negedge; cycle 1 is the
  // cycle right after the start-accept edge.
  task automatic runTxn(input logic [127:0] d, input logic [KeyW-1:0] k,
                        input logic [127:0] resp, input int finAt, input bit disturb);
    int cyc, phase, idx;
    bus.start   = 1'b1;
    bus.data_in = d;
    bus.key_in  = k;
    @(negedge clk);
    cyc = 1; phase = 0; idx = 0;
    rx = '0; csRun = 0; runCycles = 0; ovCount = 0; ovCycle = 0;
    toSeen = 1'b0; toCycle1 = bus.timeout_err; setupMiso = 1'b0; runMiso = 1'b0;
    readyDone = 1'b1; idleReady = 1'b0; idleCs = 1'b1; idleTo = 1'b0; hung = 1'b0;
    while (phase != 7) begin
      bus.start = 1'b0;
      if (bus.out_valid) begin
        ovCount++;
        if (ovCycle == 0) ovCycle = cyc;
      end
      if (bus.timeout_err) toSeen = 1'b1;
      case (phase)
        0: begin
          setupMiso = miso;
          csRun = cs ? 1 : 0;
          phase = 1;
        end
        1: begin
          if (cs) begin
            if (idx < LoadBits) rx[idx] = miso;
            idx++;
            csRun++;
            if (disturb && idx == 51) begin
              bus.start   = 1'b1;
              bus.data_in = ~d;
              bus.key_in  = ~k;
            end
          end else begin
            phase     = 2;
            runCycles = 1;
            runMiso   = runMiso | miso;
            finished  = (finAt != 0) && (finAt <= 1);
          end
        end
        2: begin
          if (bus.timeout_err) begin
            finished = 1'b0;
            phase    = 6;
          end else if (cs) begin
            finished = 1'b0;
            idx      = 0;
            phase    = 4;
          end else begin
            runCycles++;
            runMiso  = runMiso | miso;
            finished = (finAt != 0) && (runCycles >= finAt);
            if (disturb && runCycles == 2) bus.start = 1'b1;
          end
        end
        4: begin
          if (cs) begin
            if (idx < 128) mosi = resp[idx];
            idx++;
          end else begin
            mosi      = 1'b0;
            readyDone = bus.ready;
            if (disturb) bus.start = 1'b1;
            phase = 5;
          end
        end
        default: begin
          idleReady = bus.ready;
          idleCs    = cs;
          idleTo    = bus.timeout_err;
          phase     = 7;
        end
      endcase
      if (phase != 7) begin
        @(negedge clk);
        cyc++;
        if (cyc > 2000) begin
          hung  = 1'b1;
          phase = 7;
        end
      end
    end
    chk("no_hang", 384'(hung), 384'(0));
  endtask

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.data_in = '0; bus.key_in = '0;
    mosi = 1'b0; finished = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 384'(bus.ready), 384'(1));
    chk("rst_cs_miso", 384'({cs, miso}), 384'(0));
    chk("rst_ov_to", 384'({bus.out_valid, bus.timeout_err}), 384'(0));
    chk("rst_dout", 384'(bus.data_out), 384'(0));
    rst = 1'b0;
    @(negedge clk);

    // Encrypt vector 1, finished raised in RUN cycle 10.
    runTxn(D1, K1, C1, 10, 1'b0);
    chk("v1_serial", 384'(rx), 384'({K1, D1}));
    chk("v1_cs_run", 384'(csRun), 384'(321));
    chk("v1_setup_run_miso", 384'({setupMiso, runMiso}), 384'(0));
    chk("v1_run_cycles", 384'(runCycles), 384'(10));
    chk("v1_ov_count", 384'(ovCount), 384'(1));
    chk("v1_latency", 384'(ovCycle), 384'(461));
    chk("v1_ready_done", 384'(readyDone), 384'(0));
    chk("v1_dout", 384'(bus.data_out), 384'(C1));
    chk("v1_idle", 384'({idleReady, idleCs}), 384'(2'b10));

    // Encrypt vector 2; finished already high in RUN cycle 1 must be ignored.
    runTxn(D2, K2, C2, 1, 1'b0);
    chk("v2_run_cycles", 384'(runCycles), 384'(2));
    chk("v2_latency", 384'(ovCycle), 384'(453));
    chk("v2_dout", 384'(bus.data_out), 384'(C2));

    // Decrypt chaining returns the original plaintext.
    runTxn(C2, K2, D2, 5, 1'b0);
    chk("dec_serial", 384'(rx), 384'({K2, C2}));
    chk("dec_dout", 384'(bus.data_out), 384'(D2));

    // finished never rises: timeout after 64 RUN cycles.
    runTxn(D1, K1, C1, 0, 1'b0);
    chk("to_run_cycles", 384'(runCycles), 384'(64));
    chk("to_seen", 384'(toSeen), 384'(1));
    chk("to_no_ov", 384'(ovCount), 384'(0));
    chk("to_idle", 384'({idleReady, idleCs, idleTo}), 384'(3'b101));
    chk("to_dout_held", 384'(bus.data_out), 384'(D2));

    // finished on the final RUN cycle beats timeout; new start clears the flag.
    runTxn(D1, K1, C1, 64, 1'b0);
    chk("fin_edge_to_cleared", 384'(toCycle1), 384'(0));
    chk("fin_edge_run_cycles", 384'(runCycles), 384'(64));
    chk("fin_edge_ov", 384'({ovCount[1:0], toSeen}), 384'(3'b010));
    chk("fin_edge_dout", 384'(bus.data_out), 384'(C1));

    // Reset at LOAD bit 100 aborts the transaction.
    bus.start = 1'b1; bus.data_in = D2; bus.key_in = K2;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (101) @(negedge clk);
    chk("pre_rst_cs", 384'(cs), 384'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_cs_ready", 384'({cs, bus.ready}), 384'(2'b01));
    chk("mid_rst_dout", 384'(bus.data_out), 384'(0));
    ovCount = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.out_valid || cs) ovCount++;
    end
    chk("mid_rst_quiet", 384'(ovCount), 384'(0));

    // Stray starts in LOAD, RUN and DONE with data_in/key_in altered.
    runTxn(D2, K2, C2, 3, 1'b1);
    chk("dist_serial", 384'(rx), 384'({K2, D2}));
    chk("dist_run_cycles", 384'(runCycles), 384'(3));
    chk("dist_ov_count", 384'(ovCount), 384'(1));
    chk("dist_dout", 384'(bus.data_out), 384'(C2));
    @(negedge clk);
    chk("dist_done_start_ignored", 384'({bus.ready, cs}), 384'(2'b10));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
